reg_file_sb: RTL and testbench

Parametrised two-write-port, two-read-port register file with write-first bypass and a per-register pending scoreboard, for the pipelined MIPS core. Port 0 carries ALU writeback and port 1 carries load/multi-cycle writeback. The issue stage marks a destination busy when it dispatches a producer; a writeback clears the mark. Decode reads operands and busy status combinationally and stalls on busy.

---
 rtl/reg_file_sb.sv | 112 +++++++++++
 tb/tb_reg_file_sb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: two-write / two-read register file with write-first bypass
// and a per-register pending scoreboard. Port 1 wins same-address write
// collisions; an issue to an address wins over a writeback clear to it.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rbusy1,
    output logic              rbusy2,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              issue_v,
    input  logic [ADDR_W-1:0] issue_a,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DATA_W-1:0] rf_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              wen0, wen1, iss_en;
    logic [ADDR_W-1:0] ra   [2];
    logic [DATA_W-1:0] rd_v [2];
    logic              rb_v [2];

    // Qualify write/issue enables: register 0 is hard-wired when ZERO_REG=1
    always_comb begin
        wen0   = we0     && !((ZERO_REG != 0) && (wa0     == '0));
        wen1   = we1     && !((ZERO_REG != 0) && (wa1     == '0));
        iss_en = issue_v && !((ZERO_REG != 0) && (issue_a == '0));
    end

    // Read ports: reset/zero-reg force 0, then port-1 bypass, port-0 bypass, array
    always_comb begin
        ra[0] = ra1;
        ra[1] = ra2;
        for (int unsigned p = 0; p < 2; p++) begin
            rd_v[p] = rf_q[ra[p]];
            rb_v[p] = pend_q[ra[p]];
            if (!rst_n || ((ZERO_REG != 0) && (ra[p] == '0))) begin
                rd_v[p] = '0;
                rb_v[p] = 1'b0;
            end else begin
                if (wen1 && (wa1 == ra[p])) begin
                    rd_v[p] = wd1;
                    rb_v[p] = 1'b0;
                end else if (wen0 && (wa0 == ra[p])) begin
                    rd_v[p] = wd0;
                    rb_v[p] = 1'b0;
                end
            end
        end
        rd1    = rd_v[0];
        rd2    = rd_v[1];
        rbusy1 = rb_v[0];
        rbusy2 = rb_v[1];
    end

    // Next-state: writes (port 1 last so it wins), clears, then issue set so it wins
    always_comb begin
        rf_d   = rf_q;
        pend_d = pend_q;
        if (wen0) begin
            rf_d[wa0]   = wd0;
            pend_d[wa0] = 1'b0;
        end
        if (wen1) begin
            rf_d[wa1]   = wd1;
            pend_d[wa1] = 1'b0;
        end
        if (iss_en) begin
            pend_d[issue_a] = 1'b1;
        end
        cnt_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + CNT_W'(pend_d[i[ADDR_W-1:0]]);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rf_q[i[ADDR_W-1:0]] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            rf_q   <= rf_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb: a default-sized instance for
// data/bypass/scoreboard behaviour and a small ADDR_W=3 instance for count limits.
module tb_reg_file_sb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // default-size instance
    logic [4:0]  ra1, ra2, wa0, wa1, issue_a;
    logic [31:0] rd1, rd2, wd0, wd1;
    logic        rbusy1, rbusy2, we0, we1, issue_v;
    logic [5:0]  busy_cnt;

    // small instance
    logic [2:0] s_ra1, s_ra2, s_wa0, s_wa1, s_issue_a;
    logic [7:0] s_rd1, s_rd2, s_wd0, s_wd1;
    logic       s_rbusy1, s_rbusy2, s_we0, s_we1, s_issue_v;
    logic [3:0] s_busy_cnt;

    reg_file_sb dut (
        .clk(clk), .rst_n(rst_n),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .rbusy1(rbusy1), .rbusy2(rbusy2),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .issue_v(issue_v), .issue_a(issue_a),
        .busy_cnt(busy_cnt)
    );

    reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .ra1(s_ra1), .ra2(s_ra2), .rd1(s_rd1), .rd2(s_rd2),
        .rbusy1(s_rbusy1), .rbusy2(s_rbusy2),
        .we0(s_we0), .wa0(s_wa0), .wd0(s_wd0),
        .we1(s_we1), .wa1(s_wa1), .wd1(s_wd1),
        .issue_v(s_issue_v), .issue_a(s_issue_a),
        .busy_cnt(s_busy_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; issue_v = 0;
        s_we0 = 0; s_we1 = 0; s_issue_v = 0;
    endtask

    initial begin
        ra1 = 0; ra2 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; issue_a = 0;
        s_ra1 = 0; s_ra2 = 0; s_wa0 = 0; s_wa1 = 0; s_wd0 = 0; s_wd1 = 0; s_issue_a = 0;
        idle();

        // reset holds off writes and forces outputs to 0
        we0 = 1; wa0 = 3; wd0 = 32'hFFFF_FFFF; ra1 = 3;
        #1;
        check("rst_rd1_comb", rd1, 0);
        check("rst_rbusy1", rbusy1, 0);
        tick();
        check("rst_rd1", rd1, 0);
        check("rst_cnt", busy_cnt, 0);
        check("rst_s_cnt", s_busy_cnt, 0);
        rst_n = 1;
        #1;
        check("bypass_after_rst", rd1, 32'hFFFF_FFFF);
        tick();
        we0 = 0;
        #1;
        check("array_rd1_3", rd1, 32'hFFFF_FFFF);

        // bypass priority: port 1 wins on collision
        we0 = 1; wa0 = 5; wd0 = 32'h11; we1 = 1; wa1 = 5; wd1 = 32'h22; ra1 = 5;
        #1;
        check("bypass_prio", rd1, 32'h22);
        tick();
        idle();
        #1;
        check("array_prio", rd1, 32'h22);
        // port 0 bypass alone
        we0 = 1; wa0 = 6; wd0 = 32'h33; ra1 = 6;
        #1;
        check("bypass_p0", rd1, 32'h33);
        // write to reg 0 ignored
        wa0 = 0; wd0 = 32'h55; ra2 = 0;
        #1;
        check("zero_bypass", rd2, 0);
        tick();
        idle();
        #1;
        check("zero_array", rd2, 0);

        // scoreboard set then clear via writeback
        issue_v = 1; issue_a = 7; ra1 = 7;
        #1;
        check("busy_before_edge", rbusy1, 0);
        tick();
        idle();
        #1;
        check("busy_after_issue", rbusy1, 1);
        check("cnt_after_issue", busy_cnt, 1);
        we0 = 1; wa0 = 7; wd0 = 32'hAB;
        #1;
        check("busy_bypassed", rbusy1, 0);
        check("rd_bypassed", rd1, 32'hAB);
        tick();
        idle();
        #1;
        check("cnt_after_wb", busy_cnt, 0);
        check("busy_after_wb", rbusy1, 0);

        // simultaneous issue and writeback to one address: set wins
        issue_v = 1; issue_a = 9;
        tick();
        we1 = 1; wa1 = 9; wd1 = 32'h99;
        tick();
        idle();
        ra1 = 9;
        #1;
        check("set_wins_busy", rbusy1, 1);
        check("set_wins_cnt", busy_cnt, 1);
        check("set_wins_data", rd1, 32'h99);
        issue_v = 1; issue_a = 4;
        tick();
        issue_a = 6;
        tick();
        idle();
        check("cnt_three", busy_cnt, 3);
        we0 = 1; wa0 = 4; wd0 = 32'h4; we1 = 1; wa1 = 6; wd1 = 32'h6;
        tick();
        idle();
        check("double_clear", busy_cnt, 1);
        we0 = 1; wa0 = 9; wd0 = 0;
        tick();
        idle();
        check("cnt_zero_again", busy_cnt, 0);

        // small instance: count limits
        for (int r = 1; r < 8; r++) begin
            s_issue_v = 1; s_issue_a = 3'(r);
            tick();
        end
        idle();
        check("s_cnt_full", s_busy_cnt, 7);
        s_issue_v = 1; s_issue_a = 3;
        tick();
        idle();
        check("s_reissue", s_busy_cnt, 7);
        s_issue_v = 1; s_issue_a = 0; s_ra1 = 0; s_ra2 = 3;
        tick();
        idle();
        #1;
        check("s_issue_zero", s_busy_cnt, 7);
        check("s_zero_busy", s_rbusy1, 0);
        check("s_r3_busy", s_rbusy2, 1);
        s_we0 = 1; s_wa0 = 1; s_wd0 = 8'h01; s_we1 = 1; s_wa1 = 2; s_wd1 = 8'h02;
        tick();
        check("s_clear_a", s_busy_cnt, 5);
        s_wa0 = 3; s_wa1 = 4;
        tick();
        check("s_clear_b", s_busy_cnt, 3);
        s_wa0 = 5; s_wa1 = 6;
        tick();
        check("s_clear_c", s_busy_cnt, 1);
        s_we1 = 0; s_wa0 = 7;
        tick();
        check("s_clear_d", s_busy_cnt, 0);
        s_wa0 = 5; s_wd0 = 8'h5A;
        tick();
        idle();
        s_ra1 = 5;
        #1;
        check("s_no_underflow", s_busy_cnt, 0);
        check("s_rd5", s_rd1, 8'h5A);

        // asynchronous reset between edges
        issue_v = 1;
        issue_a = 1;
        tick();
        issue_a = 2;
        tick();
        issue_a = 3;
        tick();
        idle();
        check("pre_rst_cnt", busy_cnt, 3);
        we0 = 1; wa0 = 2; wd0 = 32'h77; ra1 = 2; ra2 = 3;
        #1;
        check("pre_rst_rd1", rd1, 32'h77);
        check("pre_rst_busy2", rbusy2, 1);
        #1;
        rst_n = 0;
        #1;
        check("async_cnt", busy_cnt, 0);
        check("async_busy2", rbusy2, 0);
        check("async_rd1", rd1, 0);
        idle();
        #1;
        rst_n = 1;
        ra1 = 6;
        tick();
        #1;
        check("post_rst_rf", rd1, 0);
        check("post_rst_cnt", busy_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
